// File: rtl/prog_runner.sv
// Sequencer that launches a batch of programs on an attached processor,
// measures each program's RUN time, and aborts the batch on a per-program timeout.
module prog_runner #(
    parameter int          START_LEN = 2,
    parameter logic [15:0] MAX_CYC   = 16'd50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Go,
    input  logic [2:0]  NumProgs,
    input  logic        DutAck,
    output logic        DutStart,
    output logic [2:0]  ProgIdx,
    output logic [15:0] LastCycles,
    output logic        LastValid,
    output logic [23:0] TotalCycles,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] START_END = 4'(START_LEN - 1);

    state_t      state, state_next;
    logic [3:0]  start_cnt, start_cnt_next;
    logic [15:0] run_cnt, run_cnt_next;
    logic [15:0] cnt_now;
    logic [2:0]  num_q, num_next;
    logic [2:0]  idx_next;
    logic [15:0] last_next;
    logic        valid_next;
    logic [23:0] total_next;
    logic        timeout_next;
    logic [24:0] sum;

    // cnt_now is the RUN count including the current cycle.
    assign cnt_now   = run_cnt + 16'd1;
    assign sum       = {1'b0, TotalCycles} + {9'd0, cnt_now};
    assign fsm_state = state;

    always_comb begin
        state_next     = state;
        start_cnt_next = start_cnt;
        run_cnt_next   = run_cnt;
        num_next       = num_q;
        idx_next       = ProgIdx;
        last_next      = LastCycles;
        valid_next     = 1'b0;
        total_next     = TotalCycles;
        timeout_next   = Timeout;
        case (state)
            IDLE, DONE: begin
                if (Go && NumProgs != 3'd0) begin
                    state_next     = START;
                    num_next       = NumProgs;
                    idx_next       = 3'd0;
                    total_next     = 24'd0;
                    timeout_next   = 1'b0;
                    start_cnt_next = 4'd0;
                    run_cnt_next   = 16'd0;
                end
            end
            START: begin
                run_cnt_next = 16'd0;
                if (start_cnt == START_END) begin
                    state_next = RUN;
                end else begin
                    start_cnt_next = start_cnt + 4'd1;
                end
            end
            RUN: begin
                run_cnt_next = cnt_now;
                // Ack takes priority over a timeout landing on the same cycle.
                if (DutAck) begin
                    last_next  = cnt_now;
                    valid_next = 1'b1;
                    total_next = sum[24] ? 24'hFFFFFF : sum[23:0];
                    if ({1'b0, ProgIdx} + 4'd1 == {1'b0, num_q}) begin
                        state_next = DONE;
                    end else begin
                        idx_next       = ProgIdx + 3'd1;
                        state_next     = START;
                        start_cnt_next = 4'd0;
                        run_cnt_next   = 16'd0;
                    end
                end else if (cnt_now == MAX_CYC) begin
                    timeout_next = 1'b1;
                    last_next    = MAX_CYC;
                    valid_next   = 1'b1;
                    state_next   = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            start_cnt   <= 4'd0;
            run_cnt     <= 16'd0;
            num_q       <= 3'd0;
            ProgIdx     <= 3'd0;
            LastCycles  <= 16'd0;
            LastValid   <= 1'b0;
            TotalCycles <= 24'd0;
            Timeout     <= 1'b0;
            DutStart    <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state       <= state_next;
            start_cnt   <= start_cnt_next;
            run_cnt     <= run_cnt_next;
            num_q       <= num_next;
            ProgIdx     <= idx_next;
            LastCycles  <= last_next;
            LastValid   <= valid_next;
            TotalCycles <= total_next;
            Timeout     <= timeout_next;
            // Status outputs are flops fed from the next-state decode.
            DutStart    <= (state_next == START);
            Busy        <= (state_next == START) || (state_next == RUN);
            Done        <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_prog_runner.sv
// Bench for prog_runner: each batch is planned as a list of per-program ack
// delays, and the expected per-cycle timeline is derived from that plan.
module tb_prog_runner;

    localparam int          START_LEN = 2;
    localparam logic [15:0] MAX_CYC   = 16'd20;
    localparam int          TMAX      = 512;

    logic        Clk = 1'b0;
    logic        Reset, Go, DutAck;
    logic [2:0]  NumProgs;
    logic        DutStart, LastValid, Busy, Done, Timeout;
    logic [2:0]  ProgIdx;
    logic [15:0] LastCycles;
    logic [23:0] TotalCycles;
    logic [1:0]  fsm_state;

    prog_runner #(.START_LEN(START_LEN), .MAX_CYC(MAX_CYC)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .NumProgs(NumProgs), .DutAck(DutAck),
        .DutStart(DutStart), .ProgIdx(ProgIdx), .LastCycles(LastCycles),
        .LastValid(LastValid), .TotalCycles(TotalCycles), .Busy(Busy),
        .Done(Done), .Timeout(Timeout), .fsm_state(fsm_state)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state carried between batches.
    int m_last = 0, m_total = 0, m_idx = 0;
    bit m_timeout = 0, m_done = 0;
    int plan_k[8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".DutStart"}, 32'(DutStart), 0);
        check_eq({tag, ".ProgIdx"}, 32'(ProgIdx), 0);
        check_eq({tag, ".LastCycles"}, 32'(LastCycles), 0);
        check_eq({tag, ".LastValid"}, 32'(LastValid), 0);
        check_eq({tag, ".TotalCycles"}, 32'(TotalCycles), 0);
        check_eq({tag, ".Busy"}, 32'(Busy), 0);
        check_eq({tag, ".Done"}, 32'(Done), 0);
        check_eq({tag, ".Timeout"}, 32'(Timeout), 0);
    endtask

    task automatic model_reset();
        m_last = 0; m_total = 0; m_idx = 0; m_timeout = 0; m_done = 0;
    endtask

    // Go with NumProgs=0 must leave everything as it was.
    task automatic ignore_zero(input string tag);
        @(negedge Clk);
        Go = 1'b1; NumProgs = 3'd0; DutAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            Go = 1'b0;
            check_eq({tag, ".Busy"}, 32'(Busy), 0);
            check_eq({tag, ".DutStart"}, 32'(DutStart), 0);
            check_eq({tag, ".Done"}, 32'(Done), 32'(m_done));
            check_eq({tag, ".ProgIdx"}, 32'(ProgIdx), 32'(m_idx));
            check_eq({tag, ".LastCycles"}, 32'(LastCycles), 32'(m_last));
            check_eq({tag, ".TotalCycles"}, 32'(TotalCycles), 32'(m_total));
        end
    endtask

    // Runs one batch of n programs using plan_k[]. A delay above MAX_CYC means
    // the processor never acks. abort_t>0 asserts Reset (with Go/Ack) at that sample.
    task automatic run_batch(input string tag, input int n, input bit noise, input int abort_t);
        bit          e_ds[TMAX], e_busy[TMAX], e_done[TMAX], e_lv[TMAX], e_to[TMAX], ack[TMAX];
        int          e_idx[TMAX], e_last[TMAX], e_tot[TMAX];
        int          b, lc, tot, idx, len, t_end;
        bit          to, tmo;
        for (int t = 0; t < TMAX; t++) begin
            e_ds[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_lv[t] = 0; e_to[t] = 0; ack[t] = 0;
            e_idx[t] = 0; e_last[t] = 0; e_tot[t] = 0;
        end
        b = 0; lc = m_last; tot = 0; idx = 0; to = 0;
        for (int i = 0; i < n; i++) begin
            tmo = plan_k[i] > int'(MAX_CYC);
            len = tmo ? int'(MAX_CYC) : plan_k[i];
            for (int t = b + 1; t <= b + START_LEN + len; t++) begin
                e_busy[t] = 1; e_ds[t] = (t <= b + START_LEN); e_idx[t] = i;
                e_last[t] = lc; e_tot[t] = tot; e_to[t] = 0;
            end
            if (!tmo) ack[b + START_LEN + len] = 1;
            b = b + START_LEN + len;
            e_lv[b + 1] = 1;
            lc = len; idx = i;
            if (tmo) begin
                to = 1;
                break;
            end
            tot = (tot + len > 24'hFFFFFF) ? 24'hFFFFFF : tot + len;
        end
        t_end = b + 4;
        for (int t = b + 1; t <= t_end; t++) begin
            e_done[t] = 1; e_idx[t] = idx; e_last[t] = lc; e_tot[t] = tot; e_to[t] = to;
        end

        @(negedge Clk);
        Go = 1'b1; NumProgs = 3'(n); DutAck = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int t = 1; t <= t_end; t++) begin
            @(negedge Clk);
            check_eq($sformatf("%s.t%0d.DutStart", tag, t), 32'(DutStart), 32'(e_ds[t]));
            check_eq($sformatf("%s.t%0d.Busy", tag, t), 32'(Busy), 32'(e_busy[t]));
            check_eq($sformatf("%s.t%0d.Done", tag, t), 32'(Done), 32'(e_done[t]));
            check_eq($sformatf("%s.t%0d.ProgIdx", tag, t), 32'(ProgIdx), 32'(e_idx[t]));
            check_eq($sformatf("%s.t%0d.LastValid", tag, t), 32'(LastValid), 32'(e_lv[t]));
            check_eq($sformatf("%s.t%0d.LastCycles", tag, t), 32'(LastCycles), 32'(e_last[t]));
            check_eq($sformatf("%s.t%0d.TotalCycles", tag, t), 32'(TotalCycles), 32'(e_tot[t]));
            check_eq($sformatf("%s.t%0d.Timeout", tag, t), 32'(Timeout), 32'(e_to[t]));
            if (t == abort_t) begin
                Reset = 1'b1; Go = 1'b1; NumProgs = 3'd3; DutAck = 1'b1;
                @(negedge Clk);
                check_reset_vals({tag, ".abort"});
                Reset = 1'b0; Go = 1'b0; DutAck = 1'b0;
                model_reset();
                return;
            end
            Go = 1'b0;
            if (noise && e_busy[t] && $urandom_range(0, 7) == 0) begin
                Go = 1'b1;
                NumProgs = 3'($urandom_range(1, 7));
            end
            if (ack[t])
                DutAck = 1'b1;
            else if (noise && !(e_busy[t] && !e_ds[t]))
                DutAck = 1'($urandom_range(0, 1));
            else
                DutAck = 1'b0;
        end
        Go = 1'b0; DutAck = 1'b0;
        m_last = lc; m_total = tot; m_timeout = to; m_idx = idx; m_done = 1;
    endtask

    initial begin
        Reset = 1'b1; Go = 1'b0; DutAck = 1'b0; NumProgs = 3'd0;
        repeat (3) @(negedge Clk);
        check_reset_vals("reset");
        Reset = 1'b0;
        model_reset();

        ignore_zero("zero_idle");

        plan_k[0] = 10;
        run_batch("single", 1, 0, 0);
        plan_k[0] = 5; plan_k[1] = 7; plan_k[2] = 9;
        run_batch("batch3", 3, 1, 0);
        plan_k[0] = 30;
        run_batch("timeout", 1, 0, 0);
        plan_k[0] = 20;
        run_batch("ack_at_max", 1, 0, 0);
        ignore_zero("zero_done");
        plan_k[0] = 3; plan_k[1] = 25; plan_k[2] = 4;
        run_batch("timeout_mid", 3, 0, 0);

        plan_k[0] = 5; plan_k[1] = 7; plan_k[2] = 9;
        run_batch("abort_run", 3, 0, 12);
        plan_k[0] = 4; plan_k[1] = 6;
        run_batch("restart", 2, 0, 0);
        plan_k[0] = 5;
        run_batch("abort_start", 1, 0, 1);
        ignore_zero("zero_after_abort");

        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(1, 7);
            for (int i = 0; i < 8; i++) plan_k[i] = $urandom_range(1, 24);
            run_batch($sformatf("rand%0d", r), n, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_runner.md
PROG_RUNNER -- requirements
Module: prog_runner

Interface
REQ-001 Parameter START_LEN, default 2: cycles DutStart is held high per program launch; legal range 1..15.
REQ-002 Parameter MAX_CYC, default 16'd50000: per-program cycle budget before timeout; legal range 1..65535.
REQ-003 Clk  input  1  clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  reset, synchronous, active-high.
REQ-005 Go  input  1  one-cycle request to run a batch; sampled only in IDLE or DONE.
REQ-006 NumProgs  input  3  number of programs in the batch (1..7), sampled with Go.
REQ-007 DutAck  input  1  processor done flag (level); sampled only in RUN.
REQ-008 DutStart  output  1  start request to the processor.
REQ-009 ProgIdx  output  3  index of the program currently launched or running, 0-based.
REQ-010 LastCycles  output  16  RUN-cycle count of the most recently completed program.
REQ-011 LastValid  output  1  one-cycle pulse when LastCycles updates.
REQ-012 TotalCycles  output  24  sum of RUN cycles over the batch, saturating at 24'hFFFFFF.
REQ-013 Busy  output  1  high in START or RUN.
REQ-014 Done  output  1  high in DONE.
REQ-015 Timeout  output  1  sticky; set when a program exceeds MAX_CYC.

Function
REQ-016 The FSM SHALL have states IDLE, START, RUN, DONE.
REQ-017 IDLE/DONE with Go=1 and NumProgs!=0 SHALL latch NumProgs, clear ProgIdx, TotalCycles and Timeout, and enter START next cycle.
REQ-018 Go with NumProgs=0 SHALL be ignored, leaving the state unchanged.
REQ-019 Go in START or RUN SHALL be ignored.
REQ-020 START SHALL drive DutStart=1 for exactly START_LEN consecutive cycles, then enter RUN.
REQ-021 The run counter SHALL be cleared on START entry.
REQ-022 RUN SHALL drive DutStart=0 and increment the run counter each cycle; the first RUN cycle counts as 1.
REQ-023 DutAck=1 in a RUN cycle SHALL load LastCycles with the count including that cycle, pulse LastValid the next cycle, and add the count to TotalCycles (saturating).
REQ-024 After an Ack, if ProgIdx+1 equals the latched NumProgs the FSM SHALL enter DONE; otherwise it SHALL increment ProgIdx and enter START.
REQ-025 If the count reaches MAX_CYC without Ack, the FSM SHALL set Timeout, load LastCycles=MAX_CYC, leave TotalCycles unchanged, and enter DONE; remaining programs are skipped.
REQ-026 If Ack arrives on the cycle the count equals MAX_CYC, Ack SHALL win and no timeout is flagged.
REQ-027 DutAck outside RUN SHALL have no effect.
REQ-028 Outputs SHALL be registered; DutStart SHALL go high the cycle after Go is sampled.
REQ-029 ProgIdx SHALL hold its final value in DONE until the next accepted Go.

Reset
REQ-030 Reset SHALL override all other inputs, including mid-batch.
REQ-031 Reset SHALL put the FSM in IDLE with DutStart=0, ProgIdx=0, LastCycles=0, LastValid=0, TotalCycles=0, Busy=0, Done=0, Timeout=0.
REQ-032 A Reset asserted while DutStart=1 SHALL drop DutStart on the next edge.

Verification
REQ-033 Single program: NumProgs=1, Go pulse, DUT Acks on its 10th RUN cycle -> DutStart high 2 cycles, LastCycles=10, LastValid pulses once, TotalCycles=10, Done=1, ProgIdx=0.
REQ-034 Batch: NumProgs=3, Acks at RUN cycles 5, 7, 9 -> three START phases, ProgIdx 0,1,2, TotalCycles=21, Done=1.
REQ-035 Timeout: MAX_CYC=20, no Ack -> after 20 RUN cycles Timeout=1, LastCycles=20, Done=1, DutStart stays 0.
REQ-036 Boundary: MAX_CYC=20, Ack on RUN cycle 20 -> Timeout=0, LastCycles=20; NumProgs=0 with Go -> stays IDLE.
REQ-037 Reset mid-RUN of program 1 of 3 -> next cycle IDLE, all outputs at reset values; a new Go restarts from ProgIdx=0.
REQ-038 Ack held high during START and Go pulsed during RUN -> no count update and no restart.
